// File: rtl/mem_request_arbiter_pkg.sv
// Shared types and constants for the LSB-side memory request arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_LOAD_BUSY  = 2'd1,
    ST_STORE_BUSY = 2'd2
  } arb_state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b11;

  localparam int OP_STORE = 2;

  localparam logic [1:0] IO_REGION_DEFAULT = 2'b11;

endpackage

// File: rtl/mem_request_arbiter_if.sv
// Load/store requester and memory-controller signals seen by the arbiter.
interface mem_request_arbiter_if;

  logic        loadValid;
  logic [1:0]  loadSize;
  logic        loadUnsigned;
  logic [31:0] loadAddr;
  logic        loadReady;
  logic        loadDone;
  logic [31:0] loadData;

  logic        storeValid;
  logic [1:0]  storeSize;
  logic [31:0] storeAddr;
  logic [31:0] storeData;
  logic        storeUrgent;
  logic        storeBufEmpty;
  logic        storeReady;
  logic        storeDone;

  logic        memFlag;
  logic [2:0]  memOp;
  logic [31:0] memAddr;
  logic [31:0] memWData;
  logic        memOk;
  logic [31:0] memRData;

  // Arbiter side
  modport slave (
    input  loadValid, loadSize, loadUnsigned, loadAddr,
    output loadReady, loadDone, loadData,
    input  storeValid, storeSize, storeAddr, storeData, storeUrgent, storeBufEmpty,
    output storeReady, storeDone,
    output memFlag, memOp, memAddr, memWData,
    input  memOk, memRData
  );

  // Requesters and controller side
  modport master (
    output loadValid, loadSize, loadUnsigned, loadAddr,
    input  loadReady, loadDone, loadData,
    output storeValid, storeSize, storeAddr, storeData, storeUrgent, storeBufEmpty,
    input  storeReady, storeDone,
    input  memFlag, memOp, memAddr, memWData,
    output memOk, memRData
  );

endinterface

// File: rtl/mem_request_arbiter_extender.sv
// Size-dependent sign/zero extension of the controller read buffer.
module load_data_extender
  import mem_arb_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] raw,
  output logic [31:0] ext
);

  always_comb begin
    ext = raw;
    case (size)
      SZ_BYTE: ext = {{24{raw[7]  & ~is_unsigned}}, raw[7:0]};
      SZ_HALF: ext = {{16{raw[15] & ~is_unsigned}}, raw[15:0]};
      default: ext = raw;
    endcase
  end

endmodule

// File: rtl/mem_request_arbiter.sv
// Arbitrates the LSB-side memory controller port between loads and committed
// stores, holding the granted request stable until the controller's ok.
module mem_request_arbiter
  import mem_arb_pkg::*;
#(
  parameter int         STARVE_LIMIT = 4,
  parameter logic [1:0] IO_REGION    = IO_REGION_DEFAULT
) (
  input  logic                   clockIn,
  input  logic                   resetNIn,
  input  logic                   readyIn,
  input  logic                   clearIn,
  mem_request_arbiter_if.slave   bus
);

  // The streak counter saturates at 7, so larger limits behave as 7.
  localparam int         LIMIT_SAT = (STARVE_LIMIT > 7) ? 7 : STARVE_LIMIT;
  localparam logic [2:0] LIMIT     = 3'(LIMIT_SAT);

  arb_state_t  state_q, state_d;
  logic [2:0]  streak_q, streak_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        unsigned_q, unsigned_d;
  logic        load_done_q, load_done_d;
  logic        store_done_q, store_done_d;
  logic [31:0] load_data_q, load_data_d;

  logic        io_load, load_elig, store_elig, store_win, load_win;
  logic        idle_go, load_ready, store_ready;
  logic [31:0] ext_data;

  assign io_load    = (bus.loadAddr[17:16] == IO_REGION);
  assign load_elig  = bus.loadValid & ~clearIn &
                      (~io_load | (bus.storeBufEmpty & ~bus.storeValid));
  assign store_elig = bus.storeValid;
  assign store_win  = store_elig &
                      (~load_elig | bus.storeUrgent | (streak_q >= LIMIT));
  assign load_win   = load_elig & ~store_win;

  // Readies are combinational; masking with reset keeps every output low while reset is held.
  assign idle_go     = (state_q == ST_IDLE) & readyIn & resetNIn;
  assign load_ready  = idle_go & load_win;
  assign store_ready = idle_go & store_win;

  load_data_extender u_ext (
    .size        (op_q[1:0]),
    .is_unsigned (unsigned_q),
    .raw         (bus.memRData),
    .ext         (ext_data)
  );

  always_comb begin
    state_d      = state_q;
    streak_d     = streak_q;
    op_d         = op_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    unsigned_d   = unsigned_q;
    load_done_d  = load_done_q;
    store_done_d = store_done_q;
    load_data_d  = load_data_q;

    if (readyIn) begin
      load_done_d  = 1'b0;
      store_done_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (store_ready) begin
            state_d    = ST_STORE_BUSY;
            op_d       = {1'b1, bus.storeSize};
            addr_d     = bus.storeAddr;
            wdata_d    = bus.storeData;
            unsigned_d = 1'b0;
            streak_d   = 3'd0;
          end else if (load_ready) begin
            state_d    = ST_LOAD_BUSY;
            op_d       = {1'b0, bus.loadSize};
            addr_d     = bus.loadAddr;
            wdata_d    = 32'd0;
            unsigned_d = bus.loadUnsigned;
            streak_d   = (streak_q == 3'd7) ? 3'd7 : streak_q + 3'd1;
          end
        end
        // A flush kills the load outright; the controller drops it on the same edge.
        ST_LOAD_BUSY: begin
          if (clearIn) begin
            state_d = ST_IDLE;
          end else if (bus.memOk) begin
            state_d     = ST_IDLE;
            load_done_d = 1'b1;
            load_data_d = ext_data;
          end
        end
        ST_STORE_BUSY: begin
          if (bus.memOk) begin
            state_d      = ST_IDLE;
            store_done_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clockIn or negedge resetNIn) begin
    if (!resetNIn) begin
      state_q      <= ST_IDLE;
      streak_q     <= 3'd0;
      op_q         <= 3'd0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      unsigned_q   <= 1'b0;
      load_done_q  <= 1'b0;
      store_done_q <= 1'b0;
      load_data_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      streak_q     <= streak_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      unsigned_q   <= unsigned_d;
      load_done_q  <= load_done_d;
      store_done_q <= store_done_d;
      load_data_q  <= load_data_d;
    end
  end

  // Dropping the flag on the ok cycle stops the controller re-sampling a finished request.
  assign bus.memFlag    = (state_q != ST_IDLE) & ~bus.memOk;
  assign bus.memOp      = op_q;
  assign bus.memAddr    = addr_q;
  assign bus.memWData   = wdata_q;
  assign bus.loadReady  = load_ready;
  assign bus.storeReady = store_ready;
  assign bus.loadDone   = load_done_q;
  assign bus.storeDone  = store_done_q;
  assign bus.loadData   = load_data_q;

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Scenario-driven bench for mem_request_arbiter with a load-result scoreboard.
module tb_mem_request_arbiter;

  logic clk = 1'b0;
  logic rst_n, ready, clear;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [31:0] sb[$];
  logic [7:0]  gq[$];

  always #5 clk = ~clk;

  mem_request_arbiter_if bus();

  mem_request_arbiter #(.STARVE_LIMIT(4), .IO_REGION(2'b11)) dut (
    .clockIn  (clk),
    .resetNIn (rst_n),
    .readyIn  (ready),
    .clearIn  (clear),
    .bus      (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.loadValid = 0; bus.loadSize = 2'b11; bus.loadUnsigned = 0; bus.loadAddr = 0;
    bus.storeValid = 0; bus.storeSize = 2'b11; bus.storeAddr = 0; bus.storeData = 0;
    bus.storeUrgent = 0; bus.storeBufEmpty = 1; bus.memOk = 0; bus.memRData = 0;
    clear = 0; ready = 1;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 0;
    repeat (2) tick();
    rst_n = 1;
    tick();
  endtask

  function automatic logic [31:0] ext_model(input logic [1:0] sz, input logic uns, input logic [31:0] d);
    logic [31:0] r;
    if (sz == 2'b00) r = uns ? (d & 32'hFF) : 32'($signed(d[7:0]));
    else if (sz == 2'b01) r = uns ? (d & 32'hFFFF) : 32'($signed(d[15:0]));
    else r = d;
    return r;
  endfunction

  // Full load transaction with lat cycles of controller busy time.
  task automatic run_load(input string nm, input logic [31:0] addr, input logic [1:0] sz,
                          input logic uns, input logic [31:0] rdata, input logic [31:0] expv,
                          input int lat);
    logic [31:0] want;
    bus.loadValid = 1; bus.loadAddr = addr; bus.loadSize = sz; bus.loadUnsigned = uns;
    #1;
    n_cmp++; if (bus.loadReady !== 1'b1) begin n_err++; $display("FAIL %s loadReady: got %b want 1", nm, bus.loadReady); end
    sb.push_back(expv);
    tick();
    bus.loadValid = 0;
    for (int i = 0; i < lat; i++) begin
      #1;
      n_cmp++; if (bus.memFlag !== 1'b1) begin n_err++; $display("FAIL %s memFlag c%0d: got %b want 1", nm, i + 1, bus.memFlag); end
      n_cmp++; if (bus.memAddr !== addr || bus.memOp !== {1'b0, sz}) begin
        n_err++; $display("FAIL %s memAddr/memOp: got %h/%b want %h/%b", nm, bus.memAddr, bus.memOp, addr, {1'b0, sz}); end
      tick();
    end
    bus.memOk = 1; bus.memRData = rdata;
    #1;
    n_cmp++; if (bus.memFlag !== 1'b0) begin n_err++; $display("FAIL %s memFlag on ok: got %b want 0", nm, bus.memFlag); end
    tick();
    bus.memOk = 0; bus.memRData = 32'h0;
    #1;
    n_cmp++; if (bus.loadDone !== 1'b1) begin n_err++; $display("FAIL %s loadDone: got %b want 1", nm, bus.loadDone); end
    if (sb.size() == 0) begin
      n_cmp++; n_err++; $display("FAIL %s scoreboard empty: got 0 entries want 1", nm);
    end else begin
      want = sb.pop_front();
      n_cmp++; if (bus.loadData !== want) begin n_err++; $display("FAIL %s loadData: got %h want %h", nm, bus.loadData, want); end
    end
    tick();
    n_cmp++; if (bus.loadDone !== 1'b0) begin n_err++; $display("FAIL %s loadDone pulse end: got %b want 0", nm, bus.loadDone); end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    #1;
    n_cmp++; if ({bus.memFlag, bus.loadReady, bus.storeReady, bus.loadDone, bus.storeDone} !== 5'b0) begin
      n_err++; $display("FAIL reset ctrl outs: got %b want 00000", {bus.memFlag, bus.loadReady, bus.storeReady, bus.loadDone, bus.storeDone}); end
    n_cmp++; if ({bus.memOp, bus.memAddr, bus.memWData, bus.loadData} !== 99'b0) begin
      n_err++; $display("FAIL reset data outs: got %h %h %h %h want 0", bus.memOp, bus.memAddr, bus.memWData, bus.loadData); end
    apply_reset();
  endtask

  task automatic test_load_word();
    run_load("load_word", 32'h100, 2'b11, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 4);
  endtask

  task automatic test_extension();
    logic [1:0] sz;
    logic       uns;
    logic [31:0] d;
    run_load("byte_signed",   32'h104, 2'b00, 1'b0, 32'h123456F0, 32'hFFFFFFF0, 1);
    run_load("byte_unsigned", 32'h104, 2'b00, 1'b1, 32'h123456F0, 32'h000000F0, 2);
    run_load("half_signed",   32'h108, 2'b01, 1'b0, 32'h00008001, 32'hFFFF8001, 1);
    run_load("half_unsigned", 32'h108, 2'b01, 1'b1, 32'h00008001, 32'h00008001, 1);
    for (int i = 0; i < 4; i++) begin
      sz = (i % 3 == 0) ? 2'b00 : ((i % 3 == 1) ? 2'b01 : 2'b11);
      uns = 1'($urandom_range(0, 1));
      d = $urandom;
      run_load("rand_ext", 32'h200 + 32'(i * 4), sz, uns, d, ext_model(sz, uns, d), 1);
    end
  endtask

  task automatic test_starvation();
    logic [7:0] got, want;
    apply_reset();
    gq = '{"L", "L", "L", "L", "S", "L", "L", "L", "L", "S"};
    bus.loadValid = 1; bus.loadAddr = 32'h100; bus.loadSize = 2'b11;
    bus.storeValid = 1; bus.storeAddr = 32'h400; bus.storeData = 32'hCAFE0001;
    for (int i = 0; i < 10; i++) begin
      #1;
      got = bus.storeReady ? "S" : (bus.loadReady ? "L" : "-");
      want = gq.pop_front();
      n_cmp++; if (got !== want) begin n_err++; $display("FAIL starve grant %0d: got %c want %c", i, got, want); end
      tick();
      bus.memOk = 1;
      tick();
      bus.memOk = 0;
      #1;
      n_cmp++; if ((want == "S" ? bus.storeDone : bus.loadDone) !== 1'b1) begin
        n_err++; $display("FAIL starve done %0d: got L%b S%b want %c", i, bus.loadDone, bus.storeDone, want); end
    end
    idle_inputs();
    apply_reset();
    bus.loadValid = 1; bus.loadAddr = 32'h100; bus.storeValid = 1; bus.storeUrgent = 1;
    #1;
    n_cmp++; if ({bus.storeReady, bus.loadReady} !== 2'b10) begin
      n_err++; $display("FAIL urgent grant: got S%b L%b want S1 L0", bus.storeReady, bus.loadReady); end
    bus.storeUrgent = 0;
    #1;
    n_cmp++; if ({bus.storeReady, bus.loadReady} !== 2'b01) begin
      n_err++; $display("FAIL non-urgent grant: got S%b L%b want S0 L1", bus.storeReady, bus.loadReady); end
    idle_inputs();
    tick();
  endtask

  task automatic test_io_order();
    bus.loadValid = 1; bus.loadAddr = 32'h0003_0000; bus.loadSize = 2'b11; bus.storeBufEmpty = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (bus.loadReady !== 1'b0) begin n_err++; $display("FAIL io blocked %0d: got %b want 0", i, bus.loadReady); end
      tick();
    end
    bus.storeBufEmpty = 1; bus.storeValid = 1;
    #1;
    n_cmp++; if ({bus.loadReady, bus.storeReady} !== 2'b01) begin
      n_err++; $display("FAIL io vs pending store: got L%b S%b want L0 S1", bus.loadReady, bus.storeReady); end
    bus.storeValid = 0;
    run_load("io_load", 32'h0003_0000, 2'b11, 1'b0, 32'h5A5A1234, 32'h5A5A1234, 1);
    bus.storeBufEmpty = 0;
    run_load("nonio_load", 32'h0001_0000, 2'b11, 1'b0, 32'h00C0FFEE, 32'h00C0FFEE, 1);
    bus.storeBufEmpty = 1;
  endtask

  task automatic test_clear();
    bus.loadValid = 1; bus.loadAddr = 32'h300; clear = 1;
    #1;
    n_cmp++; if (bus.loadReady !== 1'b0) begin n_err++; $display("FAIL clear idle loadReady: got %b want 0", bus.loadReady); end
    tick();
    clear = 0;
    #1;
    n_cmp++; if (bus.memFlag !== 1'b0) begin n_err++; $display("FAIL clear idle accepted: got memFlag %b want 0", bus.memFlag); end
    tick();
    bus.loadValid = 0; clear = 1;
    #1;
    n_cmp++; if (bus.memFlag !== 1'b1) begin n_err++; $display("FAIL clear load busy: got memFlag %b want 1", bus.memFlag); end
    tick();
    clear = 0; bus.memOk = 1;
    #1;
    n_cmp++; if (bus.loadDone !== 1'b0) begin n_err++; $display("FAIL clear load no done: got %b want 0", bus.loadDone); end
    tick();
    bus.memOk = 0;
    n_cmp++; if ({bus.loadDone, bus.storeDone, bus.memFlag} !== 3'b000) begin
      n_err++; $display("FAIL ok in idle: got %b want 000", {bus.loadDone, bus.storeDone, bus.memFlag}); end
    bus.storeValid = 1; bus.storeSize = 2'b01; bus.storeAddr = 32'h500; bus.storeData = 32'h0000BEEF;
    #1;
    n_cmp++; if (bus.storeReady !== 1'b1) begin n_err++; $display("FAIL store accept: got %b want 1", bus.storeReady); end
    tick();
    bus.storeValid = 0; clear = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++; if ({bus.memFlag, bus.memOp, bus.memAddr, bus.memWData} !== {1'b1, 3'b101, 32'h500, 32'h0000BEEF}) begin
        n_err++; $display("FAIL store hold %0d: got %b %b %h %h want 1 101 500 0000beef", i, bus.memFlag, bus.memOp, bus.memAddr, bus.memWData); end
      tick();
    end
    bus.memOk = 1;
    tick();
    bus.memOk = 0; clear = 0;
    #1;
    n_cmp++; if (bus.storeDone !== 1'b1) begin n_err++; $display("FAIL clear store done: got %b want 1", bus.storeDone); end
    tick();
    n_cmp++; if (bus.storeDone !== 1'b0) begin n_err++; $display("FAIL store done pulse end: got %b want 0", bus.storeDone); end
  endtask

  task automatic test_ready_low();
    bus.loadValid = 1; bus.loadAddr = 32'h600; bus.loadSize = 2'b11;
    tick();
    bus.loadValid = 0; ready = 0; bus.memOk = 1;
    tick();
    ready = 1; bus.memOk = 0;
    #1;
    n_cmp++; if (bus.memFlag !== 1'b1) begin n_err++; $display("FAIL frozen ok ignored: got memFlag %b want 1", bus.memFlag); end
    bus.memOk = 1; bus.memRData = 32'h87654321;
    tick();
    bus.memOk = 0; ready = 0; bus.loadValid = 1;
    #1;
    n_cmp++; if (bus.loadReady !== 1'b0) begin n_err++; $display("FAIL ready low accept: got %b want 0", bus.loadReady); end
    tick();
    n_cmp++; if ({bus.loadDone, bus.loadData} !== {1'b1, 32'h87654321}) begin
      n_err++; $display("FAIL done held: got %b %h want 1 87654321", bus.loadDone, bus.loadData); end
    bus.loadValid = 0; ready = 1;
    tick();
    n_cmp++; if (bus.loadDone !== 1'b0) begin n_err++; $display("FAIL done release: got %b want 0", bus.loadDone); end
  endtask

  task automatic test_reset_mid_store();
    bus.storeValid = 1; bus.storeSize = 2'b11; bus.storeAddr = 32'h700; bus.storeData = 32'h11223344;
    tick();
    bus.storeValid = 0;
    #3;
    rst_n = 0;
    #1;
    n_cmp++; if ({bus.memFlag, bus.loadReady, bus.storeReady, bus.loadDone, bus.storeDone} !== 5'b0) begin
      n_err++; $display("FAIL midreset ctrl: got %b want 00000", {bus.memFlag, bus.loadReady, bus.storeReady, bus.loadDone, bus.storeDone}); end
    n_cmp++; if ({bus.memOp, bus.memAddr, bus.memWData, bus.loadData} !== 99'b0) begin
      n_err++; $display("FAIL midreset data: got %h %h %h %h want 0", bus.memOp, bus.memAddr, bus.memWData, bus.loadData); end
    #2;
    rst_n = 1;
    tick();
    bus.memOk = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.memOk = 0;
      n_cmp++; if ({bus.storeDone, bus.memFlag} !== 2'b00) begin
        n_err++; $display("FAIL post reset %0d: got done %b flag %b want 0 0", i, bus.storeDone, bus.memFlag); end
    end
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_extension();
    test_starvation();
    test_io_order();
    test_clear();
    test_ready_low();
    test_reset_mid_store();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_request_arbiter.md
# mem_request_arbiter

Shares the LSB-side port of the byte-serial memory controller between the load unit and the committed-store buffer. Picks one requester at a time and holds its request stable until the controller's `ok`. Returns sign- or zero-extended load data. Enforces two rules: I/O loads do not overtake stores, and stores are never starved. Sits between the LSB/store buffer and the memory controller; the icache keeps its own direct port.

## Interface
- `STARVE_LIMIT`, default 4: consecutive load grants allowed while a store waits.
- `IO_REGION`, default 2'b11: value of addr[17:16] that marks the I/O region.
- `clockIn` in 1: the only clock.
- `resetNIn` in 1: asynchronous, active-low reset.
- `readyIn` in 1: global enable; when low, all state is frozen.
- `clearIn` in 1: branch-mispredict flush.
- `loadValid` in 1: load request present.
- `loadSize` in 2: 00 byte, 01 half, 11 word.
- `loadUnsigned` in 1: zero-extend (1) or sign-extend (0).
- `loadAddr` in 32: load address.
- `loadReady` out 1: load accepted this cycle.
- `loadDone` out 1: one-cycle pulse with the load result.
- `loadData` out 32: extended load result.
- `storeValid` in 1: store request present.
- `storeSize` in 2: store size.
- `storeAddr` in 32: store address.
- `storeData` in 32: store data.
- `storeUrgent` in 1: store buffer nearly full.
- `storeBufEmpty` in 1: no committed stores queued.
- `storeReady` out 1: store accepted this cycle.
- `storeDone` out 1: one-cycle pulse when the store completes.
- `memFlag` out 1: request to the controller.
- `memOp` out 3: [2]=store, [1:0]=size.
- `memAddr` out 32: request address.
- `memWData` out 32: store data to the controller.
- `memOk` in 1: controller completion pulse.
- `memRData` in 32: controller read buffer.

## Operation
- Three states, each with a latched request:
  - `IDLE`
  - `LOAD_BUSY`
  - `STORE_BUSY`
- Load eligibility in `IDLE`:
  - `loadValid & ~clearIn`.
  - If loadAddr[17:16]==IO_REGION, the load additionally requires `storeBufEmpty & ~storeValid`.
- Store eligibility in `IDLE`: `storeValid`. Stores are not affected by `clearIn`.
- Grant rules:
  - Store wins if it is eligible and any of these hold: no eligible load, `storeUrgent`, or `loadStreak >= STARVE_LIMIT`.
  - Otherwise an eligible load wins.
- `loadReady` and `storeReady` are combinational and are asserted only in `IDLE & readyIn` for the winner. Acceptance latches op/addr/data and enters the matching BUSY state.
- `loadStreak` (3 bits, saturating):
  - +1 on each load grant.
  - Cleared on each store grant.
- `memFlag = busy & ~memOk` (combinational). This ensures the controller, which returns to idle on its `ok` cycle, never re-samples a finished request.
- `memOp`, `memAddr`, `memWData` are held constant throughout BUSY.
- On `memOk` in BUSY:
  - Return to `IDLE`.
  - Next cycle, pulse `loadDone` or `storeDone`.
  - `loadData` is registered at the same time.
- Load extension, using only the low bytes of `memRData`:
  - byte: [7:0], extended by bit 7 or zero-filled.
  - half: [15:0], extended by bit 15 or zero-filled.
  - word: passed through unchanged.
- `clearIn & readyIn`:
  - In `LOAD_BUSY`: go to `IDLE`, no `loadDone`. The controller aborts its load on the same edge.
  - In `STORE_BUSY`: no effect; the store completes and `storeDone` fires.
  - In `IDLE`: no load is accepted that cycle.
- `readyIn` low: no accept, no state change. Done pulses already asserted stay asserted until the next `readyIn` cycle.

## Timing
- Reset values: every output is 0; state `IDLE`; `loadStreak` 0; latched request fields 0.
- Reset is asynchronous and can abort a BUSY request mid-transfer. No done pulse follows.
- Latency:
  - Accept at edge N; `memFlag` high from cycle N+1.
  - `memOk` at cycle M; done pulse at M+1.
  - Earliest next accept is at edge M+1, giving one bubble between back-to-back requests.
- `memOk` arriving while in `IDLE` is ignored.

## Structure
- Package `mem_arb_pkg` holds:
  - state enum `arb_state_t`
  - size constants `SZ_BYTE`/`SZ_HALF`/`SZ_WORD`
  - op bit position `OP_STORE`
  - default `IO_REGION`
- One sub-module, `load_data_extender`: combinational size/sign extension of `memRData`.

## Test plan
- Load word at 0x100, `memRData`=0xDEADBEEF, `memOk` at cycle 5:
  - `memFlag` high in cycles 1–4, low in cycle 5.
  - `loadDone` in cycle 6 with `loadData`=0xDEADBEEF.
- Load byte signed vs unsigned, `memRData`=0x123456F0:
  - signed: `loadData`=0xFFFFFFF0.
  - unsigned: `loadData`=0x000000F0.
  - Repeat for half with 0x0000_8001, expecting 0xFFFF8001 (signed).
- `loadValid` and `storeValid` held continuously, STARVE_LIMIT=4:
  - grant order L,L,L,L,S,L,L,L,L,S.
  - With `storeUrgent` high, S is granted first.
- Load at 0x30000 while `storeBufEmpty`=0:
  - `loadReady` stays 0.
  - Once `storeBufEmpty`=1 and `storeValid`=0, the load is granted.
- `clearIn` during `LOAD_BUSY`:
  - no `loadDone`; state returns to `IDLE` the next cycle.
  - `clearIn` during `STORE_BUSY`: `storeDone` still fires after `memOk`.
- `resetNIn` low mid-`STORE_BUSY`, between clock edges:
  - all outputs 0 immediately.
  - no done pulse after release.
